// File: rtl/button_event.sv
// button_event: turns a debounced button level into one-cycle press/release/auto-repeat events
// plus an 8-bit event count. Define BUTTON_EVENT_REPEAT_EN to build the auto-repeat path.
module button_event #(
    parameter int unsigned Speed    = 50000000,
    parameter int unsigned HoldMs   = 500,
    parameter int unsigned RepeatMs = 100,
    parameter int unsigned CW       = 26
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       in,
    output logic       press,
    output logic       release_evt,
    output logic       rpt,
    output logic       held,
    output logic [7:0] count
);

    localparam int unsigned CycMs   = Speed / 1000;
    localparam int unsigned HoldCyc = CycMs * HoldMs;
    localparam int unsigned RptCyc  = CycMs * RepeatMs;
    localparam int unsigned SpanCyc = (HoldCyc > RptCyc) ? HoldCyc : RptCyc;

    localparam logic [CW-1:0] HoldLast = CW'(HoldCyc - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHold = 2'd1;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [1:0] StRpt  = 2'd2;
    localparam logic [CW-1:0] RptLast = CW'(RptCyc - 1);
`endif

    // Timer must be able to reach the longer of the two intervals.
    if (64'(SpanCyc) > (64'd1 << CW)) begin : g_cw_too_small
        $error("button_event: CW too narrow for hold/repeat interval");
    end

    logic          in_q;
    logic          rise, fall;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          held_q, held_d;
    logic [7:0]    count_q, count_d;
`ifdef BUTTON_EVENT_REPEAT_EN
    logic          rpt_q, rpt_d;
`endif

    assign rise = in & ~in_q;
    assign fall = ~in & in_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;
        count_d   = count_q;
`ifdef BUTTON_EVENT_REPEAT_EN
        rpt_d     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (rise) begin
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    state_d = StHold;
                end
            end
            StHold: begin
                timer_d = timer_q + CW'(1);
                // A fall always beats a timeout landing on the same cycle.
                if (fall) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    timer_d   = '0;
                    state_d   = StIdle;
                end else if (timer_q == HoldLast) begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    rpt_d   = 1'b1;
                    count_d = count_q + 8'd1;
                    timer_d = '0;
                    state_d = StRpt;
`else
                    timer_d = timer_q;
`endif
                end
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            StRpt: begin
                timer_d = timer_q + CW'(1);
                if (fall) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    timer_d   = '0;
                    state_d   = StIdle;
                end else if (timer_q == RptLast) begin
                    rpt_d   = 1'b1;
                    count_d = count_q + 8'd1;
                    timer_d = '0;
                end
            end
`endif
            default: begin
                timer_d = '0;
                held_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            in_q      <= 1'b0;
            state_q   <= StIdle;
            timer_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            in_q      <= in;
            state_q   <= state_d;
            timer_q   <= timer_d;
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
            count_q   <= count_d;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rpt_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    assign rpt = rpt_q;
`else
    assign rpt = 1'b0;
`endif

    assign press       = press_q;
    assign release_evt = release_q;
    assign held        = held_q;
    assign count       = count_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random level runs, checked every cycle
// against an event model built from press age and repeat intervals.
module tb_button_event;

    localparam int unsigned Speed    = 1000;
    localparam int unsigned HoldMs   = 5;
    localparam int unsigned RepeatMs = 2;
    localparam int unsigned CW       = 8;
    localparam int HoldCyc = (Speed / 1000) * HoldMs;
    localparam int RptCyc  = (Speed / 1000) * RepeatMs;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       nReset;
    logic       in;
    logic       press, release_evt, rpt, held;
    logic [7:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_prev;
    int m_age;
    int m_count;
    bit e_press, e_rel, e_rpt, e_held;

    always #5 Clock = ~Clock;

    button_event #(
        .Speed   (Speed),
        .HoldMs  (HoldMs),
        .RepeatMs(RepeatMs),
        .CW      (CW)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .in         (in),
        .press      (press),
        .release_evt(release_evt),
        .rpt        (rpt),
        .held       (held),
        .count      (count)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = 1'b0;
        m_age   = 0;
        m_count = 0;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_rpt   = 1'b0;
        e_held  = 1'b0;
    endtask

    // One sampled level per clock: events follow from the edge and the press age.
    task automatic model_edge(input bit v);
        e_press = v & ~m_prev;
        e_rel   = ~v & m_prev;
        e_rpt   = 1'b0;
        if (e_press) begin
            m_age   = 0;
            m_count = (m_count + 1) % 256;
        end else if (v && m_prev) begin
            m_age++;
            if (RepeatEn && m_age >= HoldCyc && ((m_age - HoldCyc) % RptCyc) == 0) begin
                e_rpt   = 1'b1;
                m_count = (m_count + 1) % 256;
            end
        end
        e_held = v;
        m_prev = v;
    endtask

    task automatic check_all();
        chk("press", {7'd0, press}, {7'd0, e_press});
        chk("release", {7'd0, release_evt}, {7'd0, e_rel});
        chk("rpt", {7'd0, rpt}, {7'd0, e_rpt});
        chk("held", {7'd0, held}, {7'd0, e_held});
        chk("count", count, 8'(m_count));
    endtask

    task automatic step(input bit v);
        in = v;
        @(posedge Clock);
        model_edge(v);
        #1;
        check_all();
    endtask

    task automatic steps(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        nReset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        nReset = 1'b1;
    endtask

    initial begin
        int len;
        bit v;
        nReset = 1'b0;
        in     = 1'b0;
        model_reset();
        #2;
        check_all();
        #10;
        check_all();
        nReset = 1'b1;

        // Short press: one press, one release, no repeat
        steps(1'b0, 2);
        steps(1'b1, 4);
        steps(1'b0, 2);
        chk("short_count", count, 8'd1);

        // Long hold: repeats at 5, 7, 9, 11 cycles after press when enabled
        steps(1'b1, 12);
        chk("hold_count", count, RepeatEn ? 8'd6 : 8'd2);
        steps(1'b0, 2);

        // Fall on the edge that would time out
        steps(1'b1, 5);
        step(1'b0);
        chk("conflict_count", count, RepeatEn ? 8'd7 : 8'd3);
        step(1'b0);

        // Long hold for the saturating configuration
        steps(1'b1, 20);
        steps(1'b0, 2);

        // Reset mid-repeat with button still held: press on first edge after reset
        steps(1'b1, 8);
        do_reset();
        step(1'b1);
        chk("reheld_press", {7'd0, press}, 8'd1);
        steps(1'b1, 3);
        steps(1'b0, 2);

        // 256 short presses from zero wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1);
            step(1'b0);
        end
        chk("wrap_count", count, 8'd0);

        // Random level runs with occasional resets
        for (int b = 0; b < 120; b++) begin
            len = $urandom_range(1, 14);
            v   = ($urandom_range(0, 3) != 0) ? ~in : in;
            for (int i = 0; i < len; i++) step(v);
            if ((b % 40) == 39) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
